// File: rtl/dmem_scan_pkg.sv
// dmem_scan_pkg: state encoding and bus constants shared by the dmem_scan engine
package dmem_scan_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0] DWE_NONE = 4'h0;
  localparam logic [3:0] DWE_ALL = 4'hF;
endpackage

// File: rtl/dmem_scan_cmp.sv
// dmem_scan_cmp: masked word compare, hit when every masked bit of data equals pattern
module dmem_scan_cmp (
  input  logic [31:0] i_data,
  input  logic [31:0] i_pattern,
  input  logic [31:0] i_mask,
  output logic        o_hit
);
  assign o_hit = ((i_data ^ i_pattern) & i_mask) == 32'h0;
endmodule

// File: rtl/dmem_scan.sv
// dmem_scan: dmem bus initiator that scans a word region and logs masked-match addresses.
// Define DMEM_SCAN_FIRST_ONLY_EN to finish after the first logged match.
module dmem_scan
  import dmem_scan_pkg::*;
#(
  parameter int MAX_MATCHES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      pattern,
  input  logic [31:0]      mask,
  input  logic [31:0]      result_addr,
  output logic [31:0]      daddr,
  output logic [31:0]      dwdata,
  output logic [3:0]       dwe,
  input  logic [31:0]      drdata,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);
  localparam int WC_W = $clog2(MAX_MATCHES + 1);

  state_t           r_state, w_next;
  logic [31:0]      r_cur_addr, r_pattern, r_mask, r_res_ptr, r_hit_addr;
  logic [CNT_W-1:0] r_remaining, r_match_count;
  logic [WC_W-1:0]  r_written;
  logic             r_overflow;
  logic             w_hit, w_can_write, w_go;
  logic [CNT_W-1:0] w_rem_dec;

  dmem_scan_cmp u_cmp (
    .i_data   (drdata),
    .i_pattern(r_pattern),
    .i_mask   (r_mask),
    .o_hit    (w_hit)
  );

  assign w_go        = start && !abort;
  assign w_rem_dec   = r_remaining - CNT_W'(1);
  assign w_can_write = r_written < WC_W'(MAX_MATCHES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = !w_go ? IDLE : (word_count == '0) ? DONE : READ;
      READ:  w_next = abort ? IDLE : (w_hit && w_can_write) ? WRITE : (w_rem_dec == '0) ? DONE : READ;
`ifdef DMEM_SCAN_FIRST_ONLY_EN
      WRITE: w_next = abort ? IDLE : DONE;
`else
      WRITE: w_next = abort ? IDLE : (r_remaining == '0) ? DONE : READ;
`endif
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // an abort edge freezes the counters so the reported totals match the last committed step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_addr    <= '0;
      r_pattern     <= '0;
      r_mask        <= '0;
      r_res_ptr     <= '0;
      r_hit_addr    <= '0;
      r_remaining   <= '0;
      r_match_count <= '0;
      r_written     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_cur_addr    <= base_addr & ~32'd3;
          r_res_ptr     <= result_addr & ~32'd3;
          r_pattern     <= pattern;
          r_mask        <= mask;
          r_remaining   <= word_count;
          r_match_count <= '0;
          r_written     <= '0;
          r_overflow    <= 1'b0;
        end
        READ: if (!abort) begin
          r_remaining <= w_rem_dec;
          r_cur_addr  <= r_cur_addr + WORD_BYTES;
          if (w_hit) begin
            if (r_match_count != '1) r_match_count <= r_match_count + CNT_W'(1);
            if (w_can_write) r_hit_addr <= r_cur_addr;
            else             r_overflow <= 1'b1;
          end
        end
        WRITE: begin
          r_res_ptr <= r_res_ptr + WORD_BYTES;
          r_written <= r_written + WC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign daddr       = (r_state == READ) ? r_cur_addr : (r_state == WRITE) ? r_res_ptr : 32'h0;
  assign dwdata      = (r_state == WRITE) ? r_hit_addr : 32'h0;
  assign dwe         = (r_state == WRITE) ? DWE_ALL : DWE_NONE;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
  assign match_count = r_match_count;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_dmem_scan.sv
// tb_dmem_scan: scoreboarded bench for dmem_scan with a behavioural data memory
module tb_dmem_scan;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic [31:0]      pattern = '0;
  logic [31:0]      mask = '0;
  logic [31:0]      result_addr = '0;
  logic [31:0]      daddr, dwdata;
  logic [3:0]       dwe;
  logic [31:0]      drdata = '0;
  logic             busy, done, overflow;
  logic [CNT_W-1:0] match_count;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         m_e, m_got;
  logic [31:0] mem[logic [31:0]];
  int          mem_ver = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  dmem_scan #(.MAX_MATCHES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .pattern(pattern), .mask(mask),
    .result_addr(result_addr), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .busy(busy), .done(done), .match_count(match_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(daddr or mem_ver) drdata = mem.exists(daddr) ? mem[daddr] : 32'h0;

  always @(posedge clk) begin
    if (dwe == 4'hF) begin
      mem[daddr] = dwdata;
      mem_ver++;
    end
  end

  // every bus cycle the engine owns is matched in order against the expected access list
  always @(negedge clk) begin
    if (reset && busy && !done) begin
      n_checks++;
      m_got = '{we: dwe, a: daddr, d: (dwe != 4'h0) ? dwdata : 32'h0};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_unexpected: got we=%h addr=%h data=%h, required no access", dwe, daddr, m_got.d);
      end else begin
        m_e = exp_q.pop_front();
        if (m_got !== m_e) begin
          n_fail++;
          $display("FAIL bus_access: got we=%h addr=%h data=%h, required we=%h addr=%h data=%h",
                   m_got.we, m_got.a, m_got.d, m_e.we, m_e.a, m_e.d);
        end
      end
    end else if (!busy) begin
      n_checks++;
      if (dwe !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_dwe: got %h, required 0", dwe);
      end
    end
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    exp_q.push_back('{we: 4'h0, a: a, d: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 4'hF, a: a, d: d});
  endtask

  task automatic preload();
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h12345678;
    mem[32'h108] = 32'hDEAD0000;
    mem[32'h10C] = 32'hCAFEF00D;
    mem[32'h110] = 32'h00000000;
    mem_ver++;
  endtask

  task automatic do_start(input logic [31:0] b, input int cnt, input logic [31:0] p,
                          input logic [31:0] m, input logic [31:0] r);
    base_addr   = b;
    word_count  = CNT_W'(cnt);
    pattern     = p;
    mask        = m;
    result_addr = r;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_queue_empty(input string tag);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_access: got %0d pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({daddr, dwdata, dwe, busy, done, match_count, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got daddr=%h dwdata=%h dwe=%h busy=%b done=%b mc=%0d ovf=%b, required all 0",
               daddr, dwdata, dwe, busy, done, match_count, overflow);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_scan_basic();
    int cyc;
    preload();
    push_rd(32'h100); push_wr(32'h800, 32'h100); push_rd(32'h104);
    push_rd(32'h108); push_wr(32'h804, 32'h108); push_rd(32'h10C);
    do_start(32'h100, 4, 32'hDEAD0000, 32'hFFFF0000, 32'h800);
    wait_done(cyc);
    n_checks++;
    if (cyc != 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, required 7", cyc); end
    n_checks++;
    if (match_count !== 16'd2 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_counts: got mc=%0d ovf=%b, required mc=2 ovf=0", match_count, overflow);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: got busy=%b done=%b, required 0 0", busy, done);
    end
    n_checks++;
    if (rd_mem(32'h800) !== 32'h100 || rd_mem(32'h804) !== 32'h108) begin
      n_fail++; $display("FAIL basic_list: got %h %h, required 00000100 00000108", rd_mem(32'h800), rd_mem(32'h804));
    end
    check_queue_empty("basic");
  endtask

  task automatic test_zero_count();
    int cyc;
    do_start(32'h100, 0, 32'h0, 32'h0, 32'h800);
    wait_done(cyc);
    n_checks++;
    if (cyc != 1 || match_count !== 16'd0) begin
      n_fail++; $display("FAIL zero_count: got cyc=%0d mc=%0d, required cyc=1 mc=0", cyc, match_count);
    end
    @(posedge clk); #1;
    check_queue_empty("zero");
  endtask

  task automatic test_overflow();
    int cyc;
    push_rd(32'h100); push_wr(32'h800, 32'h100); push_rd(32'h104); push_wr(32'h804, 32'h104);
    push_rd(32'h108); push_rd(32'h10C); push_rd(32'h110);
    do_start(32'h100, 5, 32'h0, 32'h0, 32'h800);
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || match_count !== 16'd5 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow: got cyc=%0d mc=%0d ovf=%b, required cyc=8 mc=5 ovf=1", cyc, match_count, overflow);
    end
    @(posedge clk); #1;
    check_queue_empty("overflow");
  endtask

  task automatic test_abort();
    int bad_done;
    push_rd(32'h100); push_wr(32'h800, 32'h100); push_rd(32'h104);
    do_start(32'h100, 4, 32'h0, 32'h0, 32'h800);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h200;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || match_count !== 16'd1) begin
      n_fail++; $display("FAIL abort_stop: got busy=%b mc=%0d, required busy=0 mc=1", busy, match_count);
    end
    bad_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) bad_done++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done cycles, required 0", bad_done); end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_wins: got busy=%b, required 0", busy); end
    @(posedge clk); #1;
    check_queue_empty("abort");
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    push_rd(32'h100);
    do_start(32'h100, 4, 32'h0, 32'h0, 32'h800);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (daddr !== 32'h0 || dwe !== 4'h0 || busy !== 1'b0 || match_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_write: got daddr=%h dwe=%h busy=%b mc=%0d, required 0 0 0 0", daddr, dwe, busy, match_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_queue_empty("reset_mid");
    push_rd(32'h100); push_wr(32'h900, 32'h100); push_rd(32'h104);
    push_rd(32'h108); push_wr(32'h904, 32'h108); push_rd(32'h10C);
    do_start(32'h100, 4, 32'hDEAD0000, 32'hFFFF0000, 32'h900);
    wait_done(cyc);
    n_checks++;
    if (cyc != 7 || match_count !== 16'd2) begin
      n_fail++; $display("FAIL reset_rescan: got cyc=%0d mc=%0d, required cyc=7 mc=2", cyc, match_count);
    end
    n_checks++;
    if (rd_mem(32'h900) !== 32'h100 || rd_mem(32'h904) !== 32'h108) begin
      n_fail++; $display("FAIL reset_rescan_list: got %h %h, required 00000100 00000108", rd_mem(32'h900), rd_mem(32'h904));
    end
    @(posedge clk); #1;
    check_queue_empty("rescan");
  endtask

  task automatic test_wrap_align();
    int cyc;
    push_rd(32'hFFFFFFFC); push_wr(32'h800, 32'hFFFFFFFC); push_rd(32'h0); push_wr(32'h804, 32'h0);
    do_start(32'hFFFFFFFC, 2, 32'h0, 32'h0, 32'h800);
    wait_done(cyc);
    n_checks++;
    if (cyc != 5 || match_count !== 16'd2 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap: got cyc=%0d mc=%0d ovf=%b, required cyc=5 mc=2 ovf=0", cyc, match_count, overflow);
    end
    @(posedge clk); #1;
    check_queue_empty("wrap");
    push_rd(32'h100); push_wr(32'h800, 32'h100);
    do_start(32'h103, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h802);
    wait_done(cyc);
    n_checks++;
    if (cyc != 3 || match_count !== 16'd1) begin
      n_fail++; $display("FAIL align: got cyc=%0d mc=%0d, required cyc=3 mc=1", cyc, match_count);
    end
    @(posedge clk); #1;
    check_queue_empty("align");
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_zero_count();
    test_overflow();
    test_abort();
    test_reset_mid_write();
    test_wrap_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
